// File: rtl/t_box_array_pkg.sv
// aes_tbox_pkg: AES S-box tables, GF(2^8) helpers and mode type
// shared by the T-table lookup unit (t_box_array, t_box_lane).
package aes_tbox_pkg;

  typedef enum logic {ENC = 1'b0, DEC = 1'b1} tbox_mode_e;

  localparam logic [8:0] GF_POLY = 9'h11b;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

  // a times a 4-bit constant coefficient
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] m;
    p = '0;
    m = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ m;
      m = xtime(m);
    end
    return p;
  endfunction

endpackage

// File: rtl/t_box_array_lane.sv
// t_box_lane: one byte lane; registered S/InvS lookup, then
// combinational coefficients and rotation. Macro: TBOX_DEC_EN.
module t_box_lane
  import aes_tbox_pkg::*;
#(
  parameter int ROT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        dec_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [7:0]  sb_q, sb_d;
  logic [31:0] col;
  logic [63:0] dbl;

`ifdef TBOX_DEC_EN
  tbox_mode_e mode_q, mode_d;

  // capture the table byte and its mode when a beat is accepted
  always_comb begin
    sb_d   = sb_q;
    mode_d = mode_q;
    if (en_i) begin
      mode_d = dec_i ? DEC : ENC;
      sb_d   = dec_i ? INV_SBOX[byte_i] : SBOX[byte_i];
    end
  end

  // lookup register
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      mode_q <= ENC;
    end else begin
      sb_q   <= sb_d;
      mode_q <= mode_d;
    end
  end

  // column word for the registered mode
  always_comb begin
    col = {sb_q, sb_q, xtime(sb_q) ^ sb_q, xtime(sb_q)};
    if (mode_q == DEC)
      col = {gmul(sb_q, 4'h9), gmul(sb_q, 4'hd),
             gmul(sb_q, 4'hb), gmul(sb_q, 4'he)};
  end
`else
  logic unused_dec;
  assign unused_dec = dec_i;

  // capture the S-box byte when a beat is accepted
  always_comb begin
    sb_d = sb_q;
    if (en_i) sb_d = SBOX[byte_i];
  end

  // lookup register
  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // encrypt column word
  always_comb begin
    col = {sb_q, sb_q, xtime(sb_q) ^ sb_q, xtime(sb_q)};
  end
`endif

  assign dbl    = {col, col} << (8 * (ROT % 4));
  assign word_o = dbl[63:32];

endmodule

// File: rtl/t_box_array.sv
// t_box_array: NBYTES-lane AES T-table unit with valid/ready flow
// control and optional output register. Macro: TBOX_DEC_EN.
module t_box_array
  import aes_tbox_pkg::*;
#(
  parameter int NBYTES   = 4,
  parameter int OUT_REG  = 0,
  parameter int LANE_ROT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_dec,
  input  logic [8*NBYTES-1:0]   in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NBYTES-1:0]  out
);

  logic                 v1_q, v1_d;
  logic                 rdy1;
  logic                 ld1;
  logic [32*NBYTES-1:0] w1;

  assign in_ready = rdy1 & ~rst;
  assign ld1      = in_valid & in_ready;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    t_box_lane #(
      .ROT (LANE_ROT != 0 ? i % 4 : 0)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (ld1),
      .dec_i  (in_dec),
      .byte_i (in[8*i +: 8]),
      .word_o (w1[32*i +: 32])
    );
  end

  // lookup stage valid: refill when empty or draining
  always_comb begin
    v1_d = v1_q;
    if (rdy1) v1_d = ld1;
  end

  // lookup stage valid register
  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= v1_d;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                 v2_q, v2_d;
    logic [32*NBYTES-1:0] d2_q, d2_d;
    logic                 rdy2;

    assign rdy2      = ~v2_q | out_ready;
    assign rdy1      = ~v1_q | rdy2;
    assign out_valid = v2_q;
    assign out       = d2_q;

    // output stage takes the lookup beat when it has room
    always_comb begin
      v2_d = v2_q;
      d2_d = d2_q;
      if (rdy2) begin
        v2_d = v1_q;
        if (v1_q) d2_d = w1;
      end
    end

    // output stage registers
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end
  end else begin : g_direct
    assign rdy1      = ~v1_q | out_ready;
    assign out_valid = v1_q;
    assign out       = w1;
  end

endmodule

// File: tb/tb_t_box_array.sv
// tb_t_box_array: scoreboard bench for t_box_array, two instances
// (direct output; registered output with lane rotation).
module tb_t_box_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv0, ir0, id0, ov0, or0;
  logic [31:0]  in0;
  logic [127:0] o0;
  logic         iv1, ir1, id1, ov1, or1;
  logic [31:0]  in1;
  logic [127:0] o1;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [7:0]   sbt [256];
  logic [7:0]   isbt[256];
  int           cmp = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  t_box_array #(.NBYTES(4), .OUT_REG(0), .LANE_ROT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .in_dec(id0), .in(in0), .out_valid(ov0), .out_ready(or0),
    .out(o0));

  t_box_array #(.NBYTES(4), .OUT_REG(1), .LANE_ROT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .in_dec(id1), .in(in1), .out_valid(ov1), .out_ready(or1),
    .out(o1));

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: inverse then affine map
  function automatic logic [7:0] sbc(input logic [7:0] x);
    logic [7:0] inv, r, s;
    inv = '0;
    for (int j = 1; j < 256; j++)
      if (gm(x, j[7:0]) == 8'h01) inv = j[7:0];
    r = inv; s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [31:0] d,
                                         input logic dec,
                                         input logic rot);
    logic [127:0] r;
    logic [31:0]  w;
    logic [63:0]  ww;
    logic [7:0]   s;
    logic         de;
    de = dec;
`ifndef TBOX_DEC_EN
    de = 1'b0;
`endif
    r = '0;
    for (int l = 0; l < 4; l++) begin
      if (de) begin
        s = isbt[d[8*l +: 8]];
        w = {gm(s, 8'h09), gm(s, 8'h0d), gm(s, 8'h0b), gm(s, 8'h0e)};
      end else begin
        s = sbt[d[8*l +: 8]];
        w = {s, s, gm(s, 8'h03), gm(s, 8'h02)};
      end
      ww = {w, w} << (rot ? 8 * l : 0);
      r[32*l +: 32] = ww[63:32];
    end
    return r;
  endfunction

  task automatic drv0(input logic v, input logic d,
                      input logic [31:0] x, input logic r);
    @(negedge clk);
    iv0 = v; id0 = d; in0 = x; or0 = r;
    #1;
    if (v && ir0) q0.push_back(model(x, d, 1'b0));
  endtask

  task automatic drv1(input logic v, input logic d,
                      input logic [31:0] x, input logic r);
    @(negedge clk);
    iv1 = v; id1 = d; in1 = x; or1 = r;
    #1;
    if (v && ir1) q1.push_back(model(x, d, 1'b1));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv0 = 0; id0 = 0; in0 = '0; or0 = 1;
    iv1 = 0; id1 = 0; in1 = '0; or1 = 1;
    repeat (2) @(negedge clk);
    #1;
    cmp++; if (ir0 !== 1'b0) begin bad++; $display("FAIL rst_in_ready0: got %b want 0", ir0); end
    cmp++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_out_valid0: got %b want 0", ov0); end
    cmp++; if (o0 !== '0) begin bad++; $display("FAIL rst_out0: got %h want 0", o0); end
    cmp++; if (ir1 !== 1'b0) begin bad++; $display("FAIL rst_in_ready1: got %b want 0", ir1); end
    cmp++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid1: got %b want 0", ov1); end
    cmp++; if (o1 !== '0) begin bad++; $display("FAIL rst_out1: got %h want 0", o1); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    cmp++; if (ir0 !== 1'b1 || ir1 !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b%b want 11", ir0, ir1); end
  endtask

  task automatic test_encrypt;
    logic [127:0] e;
    drv0(1, 0, 32'h0000_0000, 1);
    drv0(1, 0, 32'h0000_0053, 1);
    e = q0.pop_front();
    cmp++; if (ov0 !== 1'b1 || o0 !== {4{32'h6363a5c6}}) begin bad++; $display("FAIL enc_zero: got %b/%h want 1/%h", ov0, o0, {4{32'h6363a5c6}}); end
    cmp++; if (o0 !== e) begin bad++; $display("FAIL enc_zero_model: got %h want %h", o0, e); end
    drv0(0, 0, 32'hdead_beef, 1);
    e = q0.pop_front();
    cmp++; if (ov0 !== 1'b1 || o0 !== {{3{32'h6363a5c6}}, 32'heded2cc1}) begin bad++; $display("FAIL enc_53: got %b/%h want 1/eded2cc1 in lane0", ov0, o0); end
    cmp++; if (o0 !== e) begin bad++; $display("FAIL enc_53_model: got %h want %h", o0, e); end
    drv0(0, 0, 32'h1234_5678, 1);
    cmp++; if (ov0 !== 1'b0) begin bad++; $display("FAIL enc_bubble: got %b want 0", ov0); end
  endtask

  task automatic test_lane_rot;
    logic [127:0] e;
    drv1(1, 0, 32'h0000_5300, 1);
    drv1(0, 0, 32'h0, 1);
    cmp++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rot_latency_early: got %b want 0", ov1); end
    drv1(0, 0, 32'h0, 1);
    e = q1.pop_front();
    cmp++; if (ov1 !== 1'b1 || o1 !== {32'hc66363a5, 32'ha5c66363, 32'hed2cc1ed, 32'h6363a5c6}) begin bad++; $display("FAIL rot_lanes: got %b/%h want 1/c66363a5a5c66363ed2cc1ed6363a5c6", ov1, o1); end
    cmp++; if (o1 !== e) begin bad++; $display("FAIL rot_model: got %h want %h", o1, e); end
  endtask

  task automatic test_dec_mix;
    logic [127:0] e;
    logic [31:0]  dz;
    int           acc;
`ifdef TBOX_DEC_EN
    dz = 32'hf4a75051;
`else
    dz = 32'h6363a5c6;
`endif
    drv0(1, 1, 32'h0, 1);
    drv0(0, 0, 32'h0, 1);
    e = q0.pop_front();
    cmp++; if (ov0 !== 1'b1 || o0 !== {4{dz}}) begin bad++; $display("FAIL dec_zero: got %b/%h want 1/%h", ov0, o0, {4{dz}}); end
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drv0(i < 8, i[0], $urandom, 1);
      if (iv0 && ir0) acc++;
      if (ov0) begin
        cmp++;
        if (q0.size() == 0) begin bad++; $display("FAIL dec_mix_extra: got %h want none", o0); end
        else begin
          e = q0.pop_front();
          if (o0 !== e) begin bad++; $display("FAIL dec_mix: got %h want %h", o0, e); end
        end
      end
    end
    cmp++; if (acc != 8 || q0.size() != 0) begin bad++; $display("FAIL dec_mix_count: got %0d accepted %0d left want 8 0", acc, q0.size()); end
  endtask

  task automatic test_stall;
    logic [31:0]  bt[4];
    logic [127:0] e, held;
    logic         stalled;
    int           idx, got;
    for (int i = 0; i < 4; i++) bt[i] = $urandom;
    idx = 0; got = 0; stalled = 0; held = '0;
    for (int c = 0; c < 16; c++) begin
      drv1(idx < 4, idx[0], bt[idx[1:0]], !(c >= 3 && c <= 5));
      if (iv1 && ir1) idx++;
      if (stalled) begin
        cmp++;
        if (ov1 !== 1'b1 || o1 !== held) begin bad++; $display("FAIL stall_hold: got %b/%h want 1/%h", ov1, o1, held); end
      end
      stalled = ov1 && !or1;
      held = o1;
      if (ov1 && or1) begin
        got++;
        cmp++;
        if (q1.size() == 0) begin bad++; $display("FAIL stall_extra: got %h want none", o1); end
        else begin
          e = q1.pop_front();
          if (o1 !== e) begin bad++; $display("FAIL stall_order: got %h want %h", o1, e); end
        end
      end
    end
    cmp++; if (got != 4 || q1.size() != 0) begin bad++; $display("FAIL stall_count: got %0d delivered want 4", got); end
  endtask

  task automatic test_reset_flush;
    logic seen;
    drv1(1, 0, $urandom, 1);
    drv1(1, 1, $urandom, 1);
    @(negedge clk);
    iv1 = 0; or1 = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; or1 = 1;
    #1;
    cmp++; if (ov1 !== 1'b0 || o1 !== '0) begin bad++; $display("FAIL flush_out: got %b/%h want 0/0", ov1, o1); end
    q1.delete();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      drv1(0, 0, $urandom, 1);
      if (ov1 !== 1'b0) seen = 1;
    end
    cmp++; if (seen) begin bad++; $display("FAIL flush_ghost: got out_valid 1 want 0"); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] e;
    for (int c = 0; c < 48; c++) begin
      drv0(c < 40 && $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom, c >= 40 || $urandom_range(0, 9) < 7);
      if (ov0 && or0) begin
        cmp++;
        if (q0.size() == 0) begin bad++; $display("FAIL b2b_extra: got %h want none", o0); end
        else begin
          e = q0.pop_front();
          if (o0 !== e) begin bad++; $display("FAIL b2b: got %h want %h", o0, e); end
        end
      end
    end
    cmp++; if (q0.size() != 0) begin bad++; $display("FAIL b2b_drain: got %0d pending want 0", q0.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbt[i] = sbc(i[7:0]);
    for (int i = 0; i < 256; i++) isbt[sbt[i]] = i[7:0];
    test_reset;
    test_encrypt;
    test_lane_rot;
    test_dec_mix;
    test_stall;
    test_reset_flush;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/t_box_array.md
# t_box_array

Pipelined, parametrised AES T-table lookup unit: maps `NBYTES` input bytes per beat to `NBYTES` 32-bit column words. In encrypt mode each word is S·{01,01,03,02}; in decrypt mode each word is InvS·{09,0d,0b,0e}. Successor to the single-byte, encrypt-only, always-enabled T lookup, adding lane count, valid/ready flow control, optional output register and per-lane table rotation. Sits between the round-key XOR and the column-combine XOR tree in the round datapath.

## Interface
- `NBYTES`, default 4: byte lanes per beat; legal range 1..16.
- `OUT_REG`, default 0: 1 adds an output pipeline stage, making latency 2.
- `LANE_ROT`, default 0: 1 rotates lane i's word left by 8·(i mod 4) bits, giving T0..T3 per lane.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: unit accepts a beat this cycle.
- `in_dec` in 1: 0 = encrypt table, 1 = decrypt table; sampled with the beat.
- `in` in 8·NBYTES: lane i is bits [8i+7:8i].
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out` out 32·NBYTES: lane i is bits [32i+31:32i].

## Operation
- Encrypt, with s = S(x): word = {s, s, 3·s, 2·s}, MSB byte first. 2·s = xtime(s); 3·s = 2·s ^ s.
- Decrypt, with t = InvS(x): word = {09·t, 0d·t, 0b·t, 0e·t}. Products use GF(2^8) with polynomial 0x11b.
- `in_dec` travels with its beat. Mixed-mode back-to-back beats are legal, and each beat uses its own mode.
- The S-box/InvS-box stage is registered, as in the existing S cell. The GF multiplies and lane rotation are combinational after that register.
- `OUT_REG`=1: the multiplier/rotation result is registered again.
- Pipeline per stage: a valid bit plus a data register.
  - A stage loads when it is empty or its beat leaves this cycle.
  - `in_ready` = !v_last | out_ready, chained backward through the stages.
  - No skid buffer, so `in_ready` depends combinationally on `out_ready`.
- Stall: while out_valid & !out_ready, `out` and `out_valid` hold stable, and no beat is lost or duplicated.
- Simultaneous accept and drain on a full pipeline gives full throughput (one beat per cycle).
- `in_valid`=0 inserts a bubble. `in` is a don't-care then and must not alter held outputs.

## Timing
- Reset values:
  - `out_valid`=0 and `out`=0.
  - All stage valids are 0 and all data registers are 0.
  - `in_ready`=0 while `rst`=1 and 1 on the first cycle after reset.
- Reset asserted mid-operation: all in-flight beats are discarded on the next edge, with no output for them.
- Latency, from the accept edge (in_valid & in_ready) to out_valid:
  - 1 cycle with `OUT_REG`=0.
  - 2 cycles with `OUT_REG`=1.
- Throughput: 1 beat per cycle with no stall.

## Configuration
- `TBOX_DEC_EN` defined: the InvS-box and {09,0d,0b,0e} multipliers are built, and `in_dec` is honoured.
- `TBOX_DEC_EN` undefined:
  - The decrypt logic is omitted.
  - `in_dec` is ignored; the port remains for interface stability.
  - Every beat produces encrypt words.

## Structure
- Package `aes_tbox_pkg` holds:
  - the S-box and InvS-box constant arrays;
  - the `xtime` and `gmul` functions;
  - the `tbox_mode_e` typedef (ENC, DEC);
  - the constant 0x11b.
- Sub-module `t_box_lane` holds one lane: the registered S/InvS lookup plus coefficient logic, instantiated NBYTES times. The top holds valid/ready control and the optional output register.

## Test plan
- Reset, NBYTES=4, in=0x00000000, encrypt, out_ready=1 → one cycle after accept, every lane = 0x6363a5c6.
- Lane 0 = 0x53, encrypt → lane 0 = 0xeded2cc1. With LANE_ROT=1, lane 1 = 0x53 → 0xed2cc1ed.
- TBOX_DEC_EN defined, in_dec=1, lane byte 0x00 → 0xf4a75051. Alternating enc/dec beats each match their own mode.
- OUT_REG=1, 4 beats streaming with out_ready held 0 for 3 cycles mid-stream → out stable during the stall, all 4 beats delivered in order, none dropped.
- rst pulsed 1 cycle with 2 beats in flight → out_valid=0 and out=0 next cycle; those beats never appear.
- TBOX_DEC_EN undefined, in_dec=1, byte 0x00 → 0x6363a5c6.
